// File: rtl/bitwise_logic_seq.sv
// Slice-serial bitwise logic unit: evaluates SLICE bits of an N-bit op per cycle,
// accumulating zero/parity flags, with valid/ready handshakes on both sides.
module bitwise_logic_seq #(
  parameter int unsigned N     = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         parity
);

  localparam int unsigned NS = N / SLICE;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [N-1:0]       a_r;
  logic [N-1:0]       b_r;
  logic [2:0]         op_r;
  logic [CW-1:0]      cnt;
  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_r;
  logic [N-1:0]       result_next;

  function automatic logic [SLICE-1:0] f_op(input logic [2:0] o,
                                            input logic [SLICE-1:0] x,
                                            input logic [SLICE-1:0] y);
    case (o)
      3'b000:  f_op = x & y;
      3'b001:  f_op = x | y;
      3'b010:  f_op = x ^ y;
      3'b011:  f_op = ~(x ^ y);
      3'b100:  f_op = ~(x & y);
      3'b101:  f_op = ~(x | y);
      3'b110:  f_op = x & ~y;
      default: f_op = x;
    endcase
  endfunction

  // Slice select and write-back are decoded per slice so no variable shift is needed.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (cnt == CW'(i)) begin
        slice_a = a_r[i*SLICE +: SLICE];
        slice_b = b_r[i*SLICE +: SLICE];
      end
    end
    slice_r     = f_op(op_r, slice_a, slice_b);
    result_next = result;
    for (int unsigned i = 0; i < NS; i++) begin
      if (cnt == CW'(i)) result_next[i*SLICE +: SLICE] = slice_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
            parity <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          result <= result_next;
          zero   <= zero & (slice_r == '0);
          parity <= parity ^ (^slice_r);
          if (cnt == CW'(NS - 1)) state <= DONE;
          else                    cnt   <= cnt + CW'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Randomised self-checking bench for bitwise_logic_seq: default 64/16 instance
// plus 64/64 and 8/1 parameter corners, checked against a whole-word model.
module tb_bitwise_logic_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, zero, parity;
  logic [2:0]  op;
  logic [63:0] a, b, result;

  logic        iv1, ir1, ov1, or1, z1, p1;
  logic [2:0]  op1;
  logic [63:0] a1, b1, r1;

  logic        iv2, ir2, ov2, or2, z2, p2;
  logic [2:0]  op2;
  logic [7:0]  a2, b2, r2;

  int n_checks = 0;
  int n_fail   = 0;

  bitwise_logic_seq #(.N(64), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .parity(parity));

  bitwise_logic_seq #(.N(64), .SLICE(64)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .result(r1),
    .zero(z1), .parity(p1));

  bitwise_logic_seq #(.N(8), .SLICE(1)) dut_bit (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op2),
    .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .result(r2),
    .zero(z2), .parity(p2));

  function automatic logic [63:0] golden(input logic [2:0] o, input logic [63:0] x,
                                         input logic [63:0] y);
    case (o)
      3'd0:    golden = x & y;
      3'd1:    golden = x | y;
      3'd2:    golden = x ^ y;
      3'd3:    golden = ~(x ^ y);
      3'd4:    golden = ~(x & y);
      3'd5:    golden = ~(x | y);
      3'd6:    golden = x & ~y;
      default: golden = x;
    endcase
  endfunction

  task automatic send_main(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    int g = 0;
    while (in_ready !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: got %b expected 1", in_ready); end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_main(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic test_reset();
    n_checks += 5;
    if (in_ready  !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (result !== 64'd0)   begin n_fail++; $display("FAIL rst_result: got %h expected 0", result); end
    if (zero !== 1'b1)      begin n_fail++; $display("FAIL rst_zero: got %b expected 1", zero); end
    if (parity !== 1'b0)    begin n_fail++; $display("FAIL rst_parity: got %b expected 0", parity); end
  endtask

  task automatic test_and_latency();
    int cyc;
    out_ready = 1'b1;
    send_main(3'd0, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF);
    n_checks += 2;
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL busy_out_valid: got %b expected 0", out_valid); end
    wait_main(cyc);
    n_checks += 4;
    if (cyc !== 4)        begin n_fail++; $display("FAIL and_latency: got %0d expected 4", cyc); end
    if (result !== 64'd0) begin n_fail++; $display("FAIL and_result: got %h expected 0", result); end
    if (zero !== 1'b1)    begin n_fail++; $display("FAIL and_zero: got %b expected 1", zero); end
    if (parity !== 1'b0)  begin n_fail++; $display("FAIL and_parity: got %b expected 0", parity); end
    @(posedge clk); #1;
    n_checks += 2;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL and_ready_after: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL and_valid_after: got %b expected 0", out_valid); end
  endtask

  task automatic test_opcode_sweep();
    logic [63:0] x = 64'h1234_5678_9ABC_DEF0;
    logic [63:0] y = 64'h0FED_CBA9_8765_4321;
    logic [63:0] e;
    int cyc;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_main(3'(k), x, y);
      wait_main(cyc);
      e = golden(3'(k), x, y);
      n_checks += 4;
      if (cyc !== 4)           begin n_fail++; $display("FAIL sweep_latency op%0d: got %0d expected 4", k, cyc); end
      if (result !== e)        begin n_fail++; $display("FAIL sweep_result op%0d: got %h expected %h", k, result, e); end
      if (zero !== (e == 0))   begin n_fail++; $display("FAIL sweep_zero op%0d: got %b expected %b", k, zero, (e == 0)); end
      if (parity !== (^e))     begin n_fail++; $display("FAIL sweep_parity op%0d: got %b expected %b", k, parity, ^e); end
      if (k == 2) begin
        n_checks += 2;
        if (result !== 64'h1DD9_9DD1_1DD9_9DD1) begin n_fail++; $display("FAIL sweep_xor_const: got %h expected 1dd99dd11dd99dd1", result); end
        if (parity !== 1'b0) begin n_fail++; $display("FAIL sweep_xor_parity: got %b expected 0", parity); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    send_main(3'd1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    wait_main(cyc);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", cyc); end
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; op = 3'($urandom_range(7)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1;
      n_checks += 3;
      if (result !== '1)      begin n_fail++; $display("FAIL bp_result c%0d: got %h expected ffffffffffffffff", k, result); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b expected 1", k, out_valid); end
      if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b expected 0", k, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks += 2;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_input_hold();
    int cyc = 0;
    out_ready = 1'b1;
    send_main(3'd0, 64'd1, 64'd1);
    while (out_valid !== 1'b1 && cyc < 100) begin
      in_valid = 1'b1; op = 3'($urandom_range(7)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    n_checks += 4;
    if (cyc !== 4)        begin n_fail++; $display("FAIL hold_latency: got %0d expected 4", cyc); end
    if (result !== 64'd1) begin n_fail++; $display("FAIL hold_result: got %h expected 1", result); end
    if (zero !== 1'b0)    begin n_fail++; $display("FAIL hold_zero: got %b expected 0", zero); end
    if (parity !== 1'b1)  begin n_fail++; $display("FAIL hold_parity: got %b expected 1", parity); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int cyc;
    out_ready = 1'b1;
    send_main(3'd2, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_F0F0_F0F0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    if (result !== 64'd0)   begin n_fail++; $display("FAIL mid_rst_result: got %h expected 0", result); end
    if (zero !== 1'b1)      begin n_fail++; $display("FAIL mid_rst_zero: got %b expected 1", zero); end
    if (parity !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_parity: got %b expected 0", parity); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_main(3'd3, 64'd0, 64'd0);
    wait_main(cyc);
    n_checks += 4;
    if (cyc !== 4)       begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 4", cyc); end
    if (result !== '1)   begin n_fail++; $display("FAIL post_rst_result: got %h expected ffffffffffffffff", result); end
    if (zero !== 1'b0)   begin n_fail++; $display("FAIL post_rst_zero: got %b expected 0", zero); end
    if (parity !== 1'b0) begin n_fail++; $display("FAIL post_rst_parity: got %b expected 0", parity); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_main();
    logic [63:0] x, y, e;
    logic [2:0]  o;
    int cyc, d;
    for (int k = 0; k < 12; k++) begin
      out_ready = 1'b0;
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; o = 3'($urandom_range(7));
      send_main(o, x, y);
      wait_main(cyc);
      d = $urandom_range(3);
      for (int j = 0; j < d; j++) begin @(posedge clk); #1; end
      e = golden(o, x, y);
      n_checks += 5;
      if (cyc !== 4)          begin n_fail++; $display("FAIL rnd_latency v%0d: got %0d expected 4", k, cyc); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid_held v%0d: got %b expected 1", k, out_valid); end
      if (result !== e)       begin n_fail++; $display("FAIL rnd_result v%0d: got %h expected %h", k, result, e); end
      if (zero !== (e == 0))  begin n_fail++; $display("FAIL rnd_zero v%0d: got %b expected %b", k, zero, (e == 0)); end
      if (parity !== (^e))    begin n_fail++; $display("FAIL rnd_parity v%0d: got %b expected %b", k, parity, ^e); end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_corner_wide();
    logic [63:0] x, y, e;
    logic [2:0]  o;
    int cyc;
    or1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; o = 3'($urandom_range(7));
      n_checks++;
      if (ir1 !== 1'b1) begin n_fail++; $display("FAIL wide_ready v%0d: got %b expected 1", k, ir1); end
      op1 = o; a1 = x; b1 = y; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0; cyc = 0;
      while (ov1 !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      e = golden(o, x, y);
      n_checks += 4;
      if (cyc !== 1)      begin n_fail++; $display("FAIL wide_latency v%0d: got %0d expected 1", k, cyc); end
      if (r1 !== e)       begin n_fail++; $display("FAIL wide_result v%0d: got %h expected %h", k, r1, e); end
      if (z1 !== (e == 0)) begin n_fail++; $display("FAIL wide_zero v%0d: got %b expected %b", k, z1, (e == 0)); end
      if (p1 !== (^e))    begin n_fail++; $display("FAIL wide_parity v%0d: got %b expected %b", k, p1, ^e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_corner_bit();
    logic [63:0] full;
    logic [7:0]  x, y, e;
    logic [2:0]  o;
    int cyc;
    or2 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      x = 8'($urandom); y = 8'($urandom); o = 3'($urandom_range(7));
      n_checks++;
      if (ir2 !== 1'b1) begin n_fail++; $display("FAIL bit_ready v%0d: got %b expected 1", k, ir2); end
      op2 = o; a2 = x; b2 = y; iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0; cyc = 0;
      while (ov2 !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      full = golden(o, {56'd0, x}, {56'd0, y});
      e = full[7:0];
      n_checks += 4;
      if (cyc !== 8)       begin n_fail++; $display("FAIL bit_latency v%0d: got %0d expected 8", k, cyc); end
      if (r2 !== e)        begin n_fail++; $display("FAIL bit_result v%0d: got %h expected %h", k, r2, e); end
      if (z2 !== (e == 0)) begin n_fail++; $display("FAIL bit_zero v%0d: got %b expected %b", k, z2, (e == 0)); end
      if (p2 !== (^e))     begin n_fail++; $display("FAIL bit_parity v%0d: got %b expected %b", k, p2, ^e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    iv1 = 1'b0; or1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    iv2 = 1'b0; or2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
    #23;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_and_latency();
    test_opcode_sweep();
    test_backpressure();
    test_input_hold();
    test_reset_midop();
    test_random_main();
    test_corner_wide();
    test_corner_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
